// File: rtl/eq_band_scheduler.sv
// EQ band gain store with round-robin, tick-aligned coefficient set issue.
// One shared gain bus; each issue is followed by a settle window.
module eq_band_scheduler #(
   parameter int NBANDS = 5,
   parameter int SETTLE = 16,
   parameter int GMAX   = 12
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [2:0]        i_band_sel,
   input  logic              i_up,
   input  logic              i_down,
   input  logic              i_sample_tick,
   output logic [NBANDS-1:0] o_set,
   output logic [15:0]       o_gain,
   output logic              o_busy,
   output logic [15:0]       o_disp_gain
);
   localparam int CW = $clog2(SETTLE + 1);
   localparam logic signed [15:0] G_HI = 16'(GMAX);
   localparam logic signed [15:0] G_LO = -G_HI;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_ISSUE,
      S_SETTLE
   } state_t;

   state_t             state_q, state_d;
   logic signed [15:0] gain_q [NBANDS];
   logic [NBANDS-1:0]  pend_q;
   logic [2:0]         band_q, band_d, last_q, pick;
   logic signed [15:0] lat_q, lat_d, pick_gain;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic signed [15:0] cur, nxt;
   logic [3:0]         idx;
   logic               sel_ok, changed, found, issuing;

   always_comb begin
      cur    = '0;
      sel_ok = 1'b0;
      for (int k = 0; k < NBANDS; k++) begin
         if (i_band_sel == 3'(k)) begin
            cur    = gain_q[k];
            sel_ok = 1'b1;
         end
      end
      nxt = cur;
      if (i_up && !i_down && cur < G_HI)
         nxt = cur + 16'sd1;
      else if (i_down && !i_up && cur > G_LO)
         nxt = cur - 16'sd1;
      changed = sel_ok && (nxt != cur);
   end

   assign o_disp_gain = cur;

   // round-robin: first pending band after last_q, wrapping
   always_comb begin
      found     = 1'b0;
      pick      = last_q;
      idx       = '0;
      pick_gain = '0;
      for (int i = 1; i <= NBANDS; i++) begin
         if (!found) begin
            idx = {1'b0, last_q} + 4'(i);
            if (idx >= 4'(NBANDS))
               idx = idx - 4'(NBANDS);
            if (pend_q[idx[2:0]]) begin
               found = 1'b1;
               pick  = idx[2:0];
            end
         end
      end
      for (int k = 0; k < NBANDS; k++) begin
         if (pick == 3'(k))
            pick_gain = gain_q[k];
      end
   end

   always_comb begin
      state_d = state_q;
      band_d  = band_q;
      lat_d   = lat_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               band_d  = pick;
               lat_d   = pick_gain;
               state_d = S_WAIT_TICK;
            end
         end
         S_WAIT_TICK: begin
            if (i_sample_tick)
               state_d = S_ISSUE;
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1))
               state_d = S_IDLE;
            else
               cnt_d = cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign issuing = (state_q == S_ISSUE);
   assign o_busy  = (state_q != S_IDLE);
   assign o_gain  = lat_q;

   always_comb begin
      o_set = '0;
      for (int k = 0; k < NBANDS; k++)
         o_set[k] = issuing && (band_q == 3'(k));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         band_q  <= '0;
         lat_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 3'(NBANDS - 1);
      end else begin
         state_q <= state_d;
         band_q  <= band_d;
         lat_q   <= lat_d;
         cnt_q   <= cnt_d;
         if (issuing)
            last_q <= band_q;
      end
   end

   // pending clears on issue only if the stored gain is what went out
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_q <= '0;
         for (int k = 0; k < NBANDS; k++)
            gain_q[k] <= '0;
      end else begin
         for (int k = 0; k < NBANDS; k++) begin
            if (changed && i_band_sel == 3'(k)) begin
               gain_q[k] <= nxt;
               pend_q[k] <= 1'b1;
            end else if (issuing && band_q == 3'(k) &&
                         gain_q[k] == lat_q) begin
               pend_q[k] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed bench for eq_band_scheduler: vector table plus
// hand-written multi-cycle sequences.
module tb_eq_band_scheduler;
   localparam int SETTLE = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  sel;
   logic        up, down, tick;
   logic [4:0]  set;
   logic [15:0] gain, disp;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;
   int base;

   typedef struct {
      logic [4:0]  s;
      logic [15:0] g;
      int          c;
   } pulse_t;

   typedef struct {
      logic [2:0]         sel;
      logic               up;
      logic               down;
      int                 reps;
      logic signed [15:0] exp;
   } vec_t;

   pulse_t pq[$];
   vec_t   vt[$];

   always #5 clk = ~clk;

   eq_band_scheduler #(.NBANDS(5), .SETTLE(SETTLE), .GMAX(12)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_band_sel   (sel),
      .i_up         (up),
      .i_down       (down),
      .i_sample_tick(tick),
      .o_set        (set),
      .o_gain       (gain),
      .o_busy       (busy),
      .o_disp_gain  (disp)
   );

   always @(negedge clk) begin
      ncyc++;
      if (set != 5'd0)
         pq.push_back('{set, gain, ncyc});
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int pset(input int i);
      return (i < pq.size()) ? int'(pq[i].s) : -1;
   endfunction

   function automatic int pgain(input int i);
      return (i < pq.size()) ? int'($signed(pq[i].g)) : -999;
   endfunction

   function automatic int pcyc(input int i);
      return (i < pq.size()) ? pq[i].c : 0;
   endfunction

   task automatic cyc(input logic [2:0] s, input logic u,
                      input logic d, input logic t);
      @(negedge clk);
      #1;
      sel  = s;
      up   = u;
      down = d;
      tick = t;
   endtask

   task automatic wait_pulses(input int want, input int per,
                              input int maxc, input string nm);
      int c = 0;
      while (pq.size() < want && c < maxc) begin
         c++;
         cyc(sel, 1'b0, 1'b0, per != 0 && (c % per) == 0);
      end
      chk(nm, pq.size() >= want, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(3'd0, 1'b0, 1'b0, 1'b0);
      cyc(3'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      sel   = 3'd0;
      up    = 1'b0;
      down  = 1'b0;
      tick  = 1'b0;
      rst_n = 1'b0;
      #3;
      chk("rst_set", int'(set), 0);
      chk("rst_gain", int'(gain), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_disp", int'(disp), 0);
      do_reset();

      // band 2 up x3, tick a few cycles later
      base = pq.size();
      repeat (3) cyc(3'd2, 1'b1, 1'b0, 1'b0);
      repeat (4) cyc(3'd2, 1'b0, 1'b0, 1'b0);
      cyc(3'd2, 1'b0, 1'b0, 1'b1);
      cyc(3'd2, 1'b0, 1'b0, 1'b0);
      chk("a_first_cnt", pq.size() - base, 1);
      chk("a_first_set", pset(base), 5'b00100);
      wait_pulses(base + 2, 4, 100, "a_second_timeout");
      chk("a_final_set", pset(base + 1), 5'b00100);
      chk("a_final_gain", pgain(base + 1), 3);
      chk("a_disp", int'($signed(disp)), 3);
      repeat (SETTLE) cyc(3'd2, 1'b0, 1'b0, 1'b0);
      chk("a_busy_settle", int'(busy), 1);
      cyc(3'd2, 1'b0, 1'b0, 1'b0);
      chk("a_busy_done", int'(busy), 0);

      // saturation at +12
      do_reset();
      base = pq.size();
      repeat (12) cyc(3'd0, 1'b1, 1'b0, 1'b0);
      wait_pulses(base + 2, 4, 200, "b_ramp_timeout");
      chk("b_ramp_gain", pgain(base + 1), 12);
      repeat (25) cyc(3'd0, 1'b0, 1'b0, 1'b0);
      chk("b_idle", int'(busy), 0);
      base = pq.size();
      cyc(3'd0, 1'b1, 1'b0, 1'b0);
      cyc(3'd0, 1'b0, 1'b0, 1'b0);
      chk("b_sat_disp", int'($signed(disp)), 12);
      for (int i = 1; i <= 40; i++)
         cyc(3'd0, 1'b0, 1'b0, (i % 4) == 0);
      chk("b_sat_noset", pq.size() - base, 0);
      cyc(3'd0, 1'b0, 1'b1, 1'b0);
      cyc(3'd0, 1'b0, 1'b0, 1'b0);
      chk("b_down_disp", int'($signed(disp)), 11);
      wait_pulses(base + 1, 4, 60, "b_down_timeout");
      chk("b_down_set", pset(base), 5'b00001);
      chk("b_down_gain", pgain(base), 11);

      // round-robin: serve 3, then 1/3/4 pending
      do_reset();
      base = pq.size();
      cyc(3'd3, 1'b1, 1'b0, 1'b0);
      cyc(3'd3, 1'b0, 1'b0, 1'b0);
      wait_pulses(base + 1, 4, 40, "c_first_timeout");
      chk("c_first_set", pset(base), 5'b01000);
      cyc(3'd1, 1'b1, 1'b0, 1'b0);
      cyc(3'd3, 1'b1, 1'b0, 1'b0);
      cyc(3'd4, 1'b1, 1'b0, 1'b0);
      base = pq.size();
      wait_pulses(base + 3, 4, 300, "c_rr_timeout");
      chk("c_rr0", pset(base), 5'b10000);
      chk("c_rr1", pset(base + 1), 5'b00010);
      chk("c_rr2", pset(base + 2), 5'b01000);
      chk("c_rr2_gain", pgain(base + 2), 2);
      chk("c_gap01", pcyc(base + 1) - pcyc(base) >= SETTLE + 2, 1);
      chk("c_gap12", pcyc(base + 2) - pcyc(base + 1) >= SETTLE + 2, 1);

      // step in the exact issue cycle of the served band
      do_reset();
      base = pq.size();
      cyc(3'd1, 1'b1, 1'b0, 1'b0);
      cyc(3'd1, 1'b0, 1'b0, 1'b0);
      cyc(3'd1, 1'b0, 1'b0, 1'b1);
      cyc(3'd1, 1'b1, 1'b0, 1'b0);
      chk("d_first_set", pset(base), 5'b00010);
      chk("d_first_gain", pgain(base), 1);
      chk("d_onehot", $countones(set), 1);
      cyc(3'd1, 1'b0, 1'b0, 1'b0);
      chk("d_disp", int'($signed(disp)), 2);
      wait_pulses(base + 2, 4, 100, "d_second_timeout");
      chk("d_second_set", pset(base + 1), 5'b00010);
      chk("d_second_gain", pgain(base + 1), 2);

      // reset during issue
      do_reset();
      cyc(3'd2, 1'b1, 1'b0, 1'b0);
      cyc(3'd2, 1'b1, 1'b0, 1'b0);
      cyc(3'd2, 1'b0, 1'b0, 1'b0);
      cyc(3'd2, 1'b0, 1'b0, 1'b1);
      cyc(3'd2, 1'b0, 1'b0, 1'b0);
      chk("f_issue_set", int'(set), 5'b00100);
      #2 rst_n = 1'b0;
      #1;
      chk("f_async_set", int'(set), 0);
      chk("f_async_busy", int'(busy), 0);
      chk("f_async_gain", int'(gain), 0);
      cyc(3'd2, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         sel = 3'(k);
         #1;
         chk($sformatf("f_gain%0d", k), int'($signed(disp)), 0);
      end
      rst_n = 1'b1;
      base = pq.size();
      cyc(3'd6, 1'b1, 1'b0, 1'b0);
      cyc(3'd2, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 40; i++)
         cyc(3'd6, 1'b0, 1'b0, (i % 4) == 0);
      chk("f_noset", pq.size() - base, 0);
      chk("f_busy", int'(busy), 0);
      chk("f_disp6", int'($signed(disp)), 0);

      // table of single-band steps and readback
      do_reset();
      vt.push_back('{3'd2, 1'b1, 1'b0, 3,  16'sd3});
      vt.push_back('{3'd2, 1'b1, 1'b1, 1,  16'sd3});
      vt.push_back('{3'd6, 1'b1, 1'b0, 1,  16'sd0});
      vt.push_back('{3'd7, 1'b0, 1'b1, 1,  16'sd0});
      vt.push_back('{3'd2, 1'b0, 1'b0, 1,  16'sd3});
      vt.push_back('{3'd4, 1'b0, 1'b1, 2, -16'sd2});
      vt.push_back('{3'd0, 1'b1, 1'b0, 14, 16'sd12});
      vt.push_back('{3'd0, 1'b0, 1'b1, 25, -16'sd12});
      vt.push_back('{3'd0, 1'b0, 1'b1, 1, -16'sd12});
      vt.push_back('{3'd0, 1'b1, 1'b0, 1, -16'sd11});
      vt.push_back('{3'd4, 1'b1, 1'b0, 1, -16'sd1});
      vt.push_back('{3'd1, 1'b0, 1'b0, 1,  16'sd0});
      for (int v = 0; v < vt.size(); v++) begin
         repeat (vt[v].reps)
            cyc(vt[v].sel, vt[v].up, vt[v].down, 1'b0);
         cyc(vt[v].sel, 1'b0, 1'b0, 1'b0);
         chk($sformatf("vec%0d", v), int'($signed(disp)),
             int'(vt[v].exp));
      end

      for (int i = 0; i < pq.size(); i++)
         chk($sformatf("onehot%0d", i), $countones(pq[i].s), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
